// File: rtl/uriscv_irq_ctrl_pkg.sv
// uriscv_irq_ctrl shared definitions: register offsets, FSM states, claim helpers.
package uriscv_irq_ctrl_pkg;

    // Register byte offsets (bits [1:0] of the bus address are ignored)
    localparam logic [7:0] IRQ_REG_PENDING = 8'h00;
    localparam logic [7:0] IRQ_REG_ENABLE  = 8'h04;
    localparam logic [7:0] IRQ_REG_EDGE    = 8'h08;
    localparam logic [7:0] IRQ_REG_CLAIM   = 8'h0C;
    localparam logic [7:0] IRQ_REG_VECBASE = 8'h10;

    // Width of a source index
    localparam int unsigned IRQ_ID_W = 5;

    // Value a CLAIM read returns when nothing can be claimed
    localparam logic [31:0] CLAIM_NONE = 32'd0;

    typedef enum logic {
        IRQ_STATE_IDLE   = 1'b0,
        IRQ_STATE_ACTIVE = 1'b1
    } irq_state_e;

    // Claim identifiers are 1-based so that 0 can mean "nothing"
    function automatic logic [31:0] irq_id_to_claim(input logic [IRQ_ID_W-1:0] id);
        return 32'(id) + 32'd1;
    endfunction

endpackage

// File: rtl/uriscv_irq_prio.sv
// uriscv_irq_prio: combinational lowest-index-wins priority encoder.
module uriscv_irq_prio
    import uriscv_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0]  i_req,
    output logic                o_valid,
    output logic [IRQ_ID_W-1:0] o_id
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (i_req[i-1]) begin
                o_valid = 1'b1;
                o_id    = IRQ_ID_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/uriscv_irq_ctrl.sv
// uriscv_irq_ctrl: memory-mapped interrupt controller with edge/level sources,
// per-source enable, lowest-index priority and a claim/complete handshake.
// Define URISCV_IRQ_SYNC_EN to insert a 2-flop synchronizer on irq_i.
module uriscv_irq_ctrl
    import uriscv_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ       = 8,
    parameter logic [31:0] VECBASE_RESET = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [7:0]         cfg_addr_i,
    input  logic               cfg_wr_i,
    input  logic               cfg_rd_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic               cfg_ack_o,
    output logic               intr_o,
    output logic [31:0]        isr_vector_o
);

    localparam int unsigned PAD_W = 32 - NUM_IRQ;

    logic [NUM_IRQ-1:0]  w_irq_src;
    logic [NUM_IRQ-1:0]  r_sample;
    logic [NUM_IRQ-1:0]  r_prev;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [NUM_IRQ-1:0]  r_enable;
    logic [NUM_IRQ-1:0]  r_edge;
    logic [31:0]         r_vecbase;
    irq_state_e          r_state;
    logic [IRQ_ID_W-1:0] r_claim_id;

    logic [7:0]          w_addr;
    logic                w_wr_pending;
    logic                w_wr_enable;
    logic                w_wr_edge;
    logic                w_wr_claim;
    logic                w_wr_vecbase;
    logic                w_rd_claim;
    logic [NUM_IRQ-1:0]  w_rise;
    logic [NUM_IRQ-1:0]  w_w1c;
    logic [NUM_IRQ-1:0]  w_to_edge;
    logic [NUM_IRQ-1:0]  w_pending_next;
    logic [NUM_IRQ-1:0]  w_active;
    logic                w_valid;
    logic [IRQ_ID_W-1:0] w_sel_id;
    logic                w_claim;
    logic                w_complete;
    logic [31:0]         w_claim_val;
    logic [31:0]         w_rdata;

    // Word-aligned decode
    assign w_addr       = cfg_addr_i & 8'hFC;
    assign w_wr_pending = cfg_wr_i && (w_addr == IRQ_REG_PENDING);
    assign w_wr_enable  = cfg_wr_i && (w_addr == IRQ_REG_ENABLE);
    assign w_wr_edge    = cfg_wr_i && (w_addr == IRQ_REG_EDGE);
    assign w_wr_claim   = cfg_wr_i && (w_addr == IRQ_REG_CLAIM);
    assign w_wr_vecbase = cfg_wr_i && (w_addr == IRQ_REG_VECBASE);
    assign w_rd_claim   = cfg_rd_i && (w_addr == IRQ_REG_CLAIM);

`ifdef URISCV_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    // Two-flop synchronizer for sources asynchronous to clk_i
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq_src = r_sync2;
`else
    assign w_irq_src = irq_i;
`endif

    // Sample register and its one-cycle history for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sample <= '0;
            r_prev   <= '0;
        end else begin
            r_sample <= w_irq_src;
            r_prev   <= r_sample;
        end
    end

    assign w_rise    = r_sample & ~r_prev;
    assign w_w1c     = w_wr_pending ? cfg_wdata_i[NUM_IRQ-1:0] : '0;
    assign w_to_edge = w_wr_edge ? (cfg_wdata_i[NUM_IRQ-1:0] & ~r_edge) : '0;

    // Pending update: level bits track the sample, edge bits latch rises
    // and a rise in the same cycle as a clear keeps the bit set.
    always_comb begin
        w_pending_next = r_pending;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (r_edge[i]) begin
                if (w_rise[i]) begin
                    w_pending_next[i] = 1'b1;
                end else if (w_w1c[i] || (w_claim && (w_sel_id == IRQ_ID_W'(i)))) begin
                    w_pending_next[i] = 1'b0;
                end
            end else begin
                w_pending_next[i] = r_sample[i] & ~w_to_edge[i];
            end
        end
    end

    // Configuration and pending registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
            r_enable  <= '0;
            r_edge    <= '0;
            r_vecbase <= VECBASE_RESET;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr_enable) begin
                r_enable <= cfg_wdata_i[NUM_IRQ-1:0];
            end
            if (w_wr_edge) begin
                r_edge <= cfg_wdata_i[NUM_IRQ-1:0];
            end
            if (w_wr_vecbase) begin
                r_vecbase <= {cfg_wdata_i[31:2], 2'b00};
            end
        end
    end

    assign w_active = r_pending & r_enable;

    uriscv_irq_prio #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .i_req   (w_active),
        .o_valid (w_valid),
        .o_id    (w_sel_id)
    );

    // A claim needs a raised request and something still active to hand out
    assign w_claim    = w_rd_claim && (r_state == IRQ_STATE_IDLE) && intr_o && w_valid;
    assign w_complete = w_wr_claim && (cfg_wdata_i == irq_id_to_claim(r_claim_id));

    // Service state machine with registered request and vector outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IRQ_STATE_IDLE;
            r_claim_id   <= '0;
            intr_o       <= 1'b0;
            isr_vector_o <= VECBASE_RESET;
        end else begin
            case (r_state)
                IRQ_STATE_IDLE: begin
                    intr_o <= w_valid;
                    if (w_valid) begin
                        isr_vector_o <= r_vecbase + (32'(w_sel_id) << 2);
                    end
                    if (w_claim) begin
                        r_state    <= IRQ_STATE_ACTIVE;
                        r_claim_id <= w_sel_id;
                        intr_o     <= 1'b0;
                    end
                end
                IRQ_STATE_ACTIVE: begin
                    intr_o <= 1'b0;
                    if (w_complete) begin
                        r_state <= IRQ_STATE_IDLE;
                    end
                end
                default: begin
                    r_state <= IRQ_STATE_IDLE;
                    intr_o  <= 1'b0;
                end
            endcase
        end
    end

    // CLAIM read value for the current state
    always_comb begin
        w_claim_val = CLAIM_NONE;
        if (r_state == IRQ_STATE_ACTIVE) begin
            w_claim_val = irq_id_to_claim(r_claim_id);
        end else if (w_claim) begin
            w_claim_val = irq_id_to_claim(w_sel_id);
        end
    end

    // Read mux over pre-write register contents
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            IRQ_REG_PENDING: w_rdata = {{PAD_W{1'b0}}, r_pending};
            IRQ_REG_ENABLE:  w_rdata = {{PAD_W{1'b0}}, r_enable};
            IRQ_REG_EDGE:    w_rdata = {{PAD_W{1'b0}}, r_edge};
            IRQ_REG_CLAIM:   w_rdata = w_claim_val;
            IRQ_REG_VECBASE: w_rdata = r_vecbase;
            default:         w_rdata = '0;
        endcase
    end

    // Registered bus response, data zero outside a read acknowledge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_ack_o   <= 1'b0;
            cfg_rdata_o <= '0;
        end else begin
            cfg_ack_o   <= cfg_rd_i | cfg_wr_i;
            cfg_rdata_o <= cfg_rd_i ? w_rdata : '0;
        end
    end

endmodule

// File: tb/tb_uriscv_irq_ctrl.sv
// Self-checking bench for uriscv_irq_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_uriscv_irq_ctrl;

    localparam int N = 8;
    localparam logic [31:0] VB_RST = 32'h0000_0000;
`ifdef URISCV_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq = '0;
    logic [7:0]   cfg_addr = '0;
    logic         cfg_wr = 1'b0;
    logic         cfg_rd = 1'b0;
    logic [31:0]  cfg_wdata = '0;
    logic [31:0]  cfg_rdata;
    logic         cfg_ack;
    logic         intr;
    logic [31:0]  isr_vector;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] irq_drv = '0;

    // Behavioural model state
    bit   [N-1:0] m_pend, m_en, m_edge;
    logic [31:0]  m_vb, m_vec, m_rdata;
    bit           m_busy, m_intr, m_ack;
    int           m_cid;
    logic [N-1:0] hist[$];

    uriscv_irq_ctrl #(
        .NUM_IRQ       (N),
        .VECBASE_RESET (VB_RST)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_i        (irq),
        .cfg_addr_i   (cfg_addr),
        .cfg_wr_i     (cfg_wr),
        .cfg_rd_i     (cfg_rd),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata),
        .cfg_ack_o    (cfg_ack),
        .intr_o       (intr),
        .isr_vector_o (isr_vector)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0;
        m_vb = VB_RST; m_vec = VB_RST; m_rdata = '0;
        m_busy = 1'b0; m_intr = 1'b0; m_ack = 1'b0; m_cid = 0;
        hist.delete();
        for (int i = 0; i < LAT + 2; i++) hist.push_back('0);
    endtask

    // One clock of the controller described in terms of its register-level rules
    task automatic model_step(input bit rd, input bit wr, input logic [7:0] addr, input logic [31:0] wd);
        int word;
        int sel;
        bit claim;
        logic [N-1:0] s, p;
        bit [N-1:0] np;
        logic [31:0] rv;
        word = int'(addr) / 4;
        s = hist[1];
        p = hist[0];
        sel = -1;
        for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) sel = i;
        claim = rd && word == 3 && !m_busy && m_intr && sel >= 0;
        case (word)
            0: rv = 32'(m_pend);
            1: rv = 32'(m_en);
            2: rv = 32'(m_edge);
            3: rv = m_busy ? 32'(m_cid + 1) : (claim ? 32'(sel + 1) : 32'd0);
            4: rv = m_vb;
            default: rv = 32'd0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (m_edge[i]) begin
                if (s[i] && !p[i]) np[i] = 1'b1;
                else if ((wr && word == 0 && wd[i]) || (claim && sel == i)) np[i] = 1'b0;
                else np[i] = m_pend[i];
            end else begin
                np[i] = (wr && word == 2 && wd[i]) ? 1'b0 : s[i];
            end
        end
        if (!m_busy) begin
            m_intr = (sel >= 0);
            if (sel >= 0) m_vec = m_vb + 32'(sel * 4);
            if (claim) begin
                m_busy = 1'b1;
                m_cid = sel;
                m_intr = 1'b0;
            end
        end else begin
            m_intr = 1'b0;
            if (wr && word == 3 && wd == 32'(m_cid + 1)) m_busy = 1'b0;
        end
        if (wr && word == 1) m_en = wd[N-1:0];
        if (wr && word == 2) m_edge = wd[N-1:0];
        if (wr && word == 4) m_vb = wd & 32'hFFFF_FFFC;
        m_pend = np;
        m_ack = rd || wr;
        m_rdata = rd ? rv : 32'd0;
        hist.push_back(irq_drv);
        void'(hist.pop_front());
    endtask

    task automatic tick(input bit rd, input bit wr, input logic [7:0] addr, input logic [31:0] wd);
        irq = irq_drv;
        cfg_rd = rd;
        cfg_wr = wr;
        cfg_addr = addr;
        cfg_wdata = wd;
        model_step(rd, wr, addr, wd);
        @(posedge clk);
        #1;
        cfg_rd = 1'b0;
        cfg_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic test_reset();
        logic [7:0] addrs[7];
        logic [31:0] exp;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h3F};
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %0b exp 0", intr); end
        checks++;
        if (isr_vector !== VB_RST) begin errors++; $display("FAIL reset_vector: got %h exp %h", isr_vector, VB_RST); end
        checks++;
        if (cfg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b exp 0", cfg_ack); end
        checks++;
        foreach (addrs[k]) begin
            exp = (addrs[k] == 8'h10) ? VB_RST : 32'h0;
            tick(1'b1, 1'b0, addrs[k], 32'h0);
            if (cfg_ack !== 1'b1) begin errors++; $display("FAIL reset_rd_ack @%h: got %0b exp 1", addrs[k], cfg_ack); end
            checks++;
            if (cfg_rdata !== exp) begin errors++; $display("FAIL reset_rd_data @%h: got %h exp %h", addrs[k], cfg_rdata, exp); end
            checks++;
            idle(1);
            if (cfg_ack !== 1'b0 || cfg_rdata !== 32'h0) begin
                errors++; $display("FAIL reset_ack_pulse @%h: ack %0b data %h exp 0/0", addrs[k], cfg_ack, cfg_rdata);
            end
            checks++;
        end
    endtask

    task automatic test_edge_claim();
        tick(1'b0, 1'b1, 8'h10, 32'h8000_0100);
        tick(1'b0, 1'b1, 8'h04, 32'h0000_000C);
        tick(1'b0, 1'b1, 8'h08, 32'h0000_0008);
        idle(4);
        for (int k = 1; k <= 3 + LAT; k++) begin
            irq_drv = (k == 1) ? 8'h08 : 8'h00;
            tick(1'b0, 1'b0, 8'h00, 32'h0);
            if (intr !== (k == 3 + LAT)) begin
                errors++; $display("FAIL edge_intr_latency cycle %0d: got %0b exp %0b", k, intr, (k == 3 + LAT));
            end
            checks++;
        end
        if (isr_vector !== 32'h8000_010C) begin errors++; $display("FAIL edge_vector: got %h exp 8000010c", isr_vector); end
        checks++;
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== 32'd4) begin errors++; $display("FAIL edge_claim_val: got %0d exp 4", cfg_rdata); end
        checks++;
        if (intr !== 1'b0) begin errors++; $display("FAIL edge_claim_intr: got %0b exp 0", intr); end
        checks++;
        tick(1'b1, 1'b0, 8'h00, 32'h0);
        if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL edge_pending_cleared: got %h exp 0", cfg_rdata); end
        checks++;
        tick(1'b0, 1'b1, 8'h0C, 32'd4);
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL edge_complete_idle: got %0d exp 0", cfg_rdata); end
        checks++;
        if (isr_vector !== 32'h8000_010C) begin errors++; $display("FAIL edge_vector_hold: got %h exp 8000010c", isr_vector); end
        checks++;
    endtask

    task automatic test_level_priority();
        tick(1'b0, 1'b1, 8'h08, 32'h0);
        irq_drv = 8'h0C;
        idle(3 + LAT);
        if (intr !== 1'b1) begin errors++; $display("FAIL level_intr: got %0b exp 1", intr); end
        checks++;
        if (isr_vector !== 32'h8000_0108) begin errors++; $display("FAIL level_vector: got %h exp 80000108", isr_vector); end
        checks++;
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== 32'd3) begin errors++; $display("FAIL level_claim_prio: got %0d exp 3", cfg_rdata); end
        checks++;
        tick(1'b0, 1'b1, 8'h0C, 32'd5);
        idle(2);
        if (intr !== 1'b0) begin errors++; $display("FAIL level_bad_complete_intr: got %0b exp 0", intr); end
        checks++;
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== 32'd3) begin errors++; $display("FAIL level_still_active: got %0d exp 3", cfg_rdata); end
        checks++;
        tick(1'b0, 1'b1, 8'h0C, 32'd3);
        idle(1);
        if (intr !== 1'b1) begin errors++; $display("FAIL level_reassert: got %0b exp 1", intr); end
        checks++;
        if (isr_vector !== 32'h8000_0108) begin errors++; $display("FAIL level_reassert_vec: got %h exp 80000108", isr_vector); end
        checks++;
        irq_drv = 8'h00;
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== m_rdata) begin errors++; $display("FAIL level_cleanup_claim: got %0d exp %0d", cfg_rdata, m_rdata); end
        checks++;
        tick(1'b0, 1'b1, 8'h0C, 32'd3);
        idle(8);
        if (intr !== 1'b0) begin errors++; $display("FAIL level_quiet: got %0b exp 0", intr); end
        checks++;
    endtask

    task automatic test_set_wins();
        tick(1'b0, 1'b1, 8'h04, 32'h0);
        tick(1'b0, 1'b1, 8'h08, 32'h08);
        irq_drv = 8'h00;
        idle(4);
        irq_drv = 8'h08;
        idle(1 + LAT);
        tick(1'b0, 1'b1, 8'h00, 32'h08);
        tick(1'b1, 1'b0, 8'h00, 32'h0);
        if (cfg_rdata !== 32'h08) begin errors++; $display("FAIL set_wins: got %h exp 08", cfg_rdata); end
        checks++;
        tick(1'b0, 1'b1, 8'h00, 32'h08);
        tick(1'b1, 1'b0, 8'h00, 32'h0);
        if (cfg_rdata !== 32'h00) begin errors++; $display("FAIL w1c_clear: got %h exp 00", cfg_rdata); end
        checks++;
        irq_drv = 8'h0C;
        idle(4);
        tick(1'b0, 1'b1, 8'h00, 32'h04);
        tick(1'b1, 1'b0, 8'h00, 32'h0);
        if (cfg_rdata !== 32'h04) begin errors++; $display("FAIL w1c_level_ignored: got %h exp 04", cfg_rdata); end
        checks++;
        irq_drv = 8'h00;
        idle(4);
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b1, 8'h10, 32'h8000_0200);
        tick(1'b0, 1'b1, 8'h04, 32'h0C);
        tick(1'b0, 1'b1, 8'h08, 32'h08);
        irq_drv = 8'h0C;
        idle(4 + LAT);
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== 32'd3) begin errors++; $display("FAIL ar_claim: got %0d exp 3", cfg_rdata); end
        checks++;
        tick(1'b1, 1'b0, 8'h00, 32'h0);
        if (cfg_rdata !== 32'h0C) begin errors++; $display("FAIL ar_pending: got %h exp 0c", cfg_rdata); end
        checks++;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (intr !== 1'b0 || cfg_ack !== 1'b0 || cfg_rdata !== 32'h0 || isr_vector !== VB_RST) begin
            errors++;
            $display("FAIL ar_outputs: intr %0b ack %0b rdata %h vec %h exp 0 0 0 %h", intr, cfg_ack, cfg_rdata, isr_vector, VB_RST);
        end
        checks++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 8'h10, 32'h0);
        if (cfg_rdata !== VB_RST) begin errors++; $display("FAIL ar_vecbase: got %h exp %h", cfg_rdata, VB_RST); end
        checks++;
        tick(1'b1, 1'b0, 8'h0C, 32'h0);
        if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL ar_claim_idle: got %0d exp 0", cfg_rdata); end
        checks++;
        tick(1'b1, 1'b0, 8'h04, 32'h0);
        if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL ar_enable: got %h exp 0", cfg_rdata); end
        checks++;
        irq_drv = 8'h00;
        idle(4);
    endtask

    task automatic test_random();
        bit rd, wr;
        logic [7:0] addr;
        logic [31:0] wd;
        int op;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) irq_drv[b] = ~irq_drv[b];
            rd = 1'b0; wr = 1'b0;
            addr = 8'(($urandom_range(0, 5) * 4) + $urandom_range(0, 3));
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) wd = wd & 32'h0000_00FF;
            op = $urandom_range(0, 9);
            case (op)
                4: rd = 1'b1;
                5: wr = 1'b1;
                6: begin rd = 1'b1; addr = 8'h0C; end
                7: begin wr = 1'b1; addr = 8'h0C; wd = m_busy ? 32'(m_cid + 1) : 32'($urandom_range(0, 9)); end
                8: begin rd = 1'b1; wr = 1'b1; end
                9: begin wr = 1'b1; addr = 8'h0C; wd = 32'($urandom_range(0, 9)); end
                default: ;
            endcase
            tick(rd, wr, addr, wd);
            if (intr !== m_intr) begin errors++; $display("FAIL rnd_intr cyc %0d: got %0b exp %0b", c, intr, m_intr); end
            checks++;
            if (isr_vector !== m_vec) begin errors++; $display("FAIL rnd_vector cyc %0d: got %h exp %h", c, isr_vector, m_vec); end
            checks++;
            if (cfg_ack !== m_ack) begin errors++; $display("FAIL rnd_ack cyc %0d: got %0b exp %0b", c, cfg_ack, m_ack); end
            checks++;
            if (cfg_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h exp %h", c, cfg_rdata, m_rdata); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_edge_claim();
        test_level_priority();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
